// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 display path: framebuffer geometry,
// blitter state encoding and the framebuffer address helper.
package chip8_pkg;

  localparam int ROW_WORDS  = 8;
  localparam int ROWS       = 64;
  localparam int ADDR_W     = 9;
  localparam int SPRITE_W   = 8;
  localparam int WORD_BITS  = 16;
  localparam int WORD_IDX_W = $clog2(ROW_WORDS);
  localparam int ROW_IDX_W  = $clog2(ROWS);
  localparam int X_W        = WORD_IDX_W + 4;
  localparam int N_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_RD0   = 3'd3,
    ST_WR0   = 3'd4,
    ST_RD1   = 3'd5,
    ST_WR1   = 3'd6,
    ST_DONE  = 3'd7
  } blit_state_e;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [ROW_IDX_W-1:0] row,
                                                input logic [WORD_IDX_W-1:0] word);
    return {row, word};
  endfunction

endpackage

// File: rtl/sprite_shifter.sv
// Aligns one sprite byte to the pixel offset inside a framebuffer word and
// splits it into the masks for the first word and the word to its right.
module sprite_shifter
  import chip8_pkg::*;
(
  input  logic [SPRITE_W-1:0]  spr_byte,
  input  logic [3:0]           x_lo,
  output logic [WORD_BITS-1:0] mask0,
  output logic [WORD_BITS-1:0] mask1,
  output logic                 straddle
);

  logic [WORD_BITS+SPRITE_W-1:0] shifted;

  // Byte sits left-aligned above a 16-bit zero field, then slides right by x
  always_comb begin
    shifted  = {spr_byte, 16'h0000} >> x_lo;
    mask0    = shifted[WORD_BITS+SPRITE_W-1:SPRITE_W];
    mask1    = {shifted[SPRITE_W-1:0], 8'h00};
    straddle = (x_lo > 4'd8);
  end

endmodule

// File: rtl/sprite_blitter.sv
// CHIP-8 DXYN / CLS engine: XOR-draws sprites into the 1 bpp framebuffer
// through its single read/write port and reports pixel collision.
module sprite_blitter
  import chip8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_draw,
  input  logic                 cmd_cls,
  input  logic [6:0]           pos_x,
  input  logic [5:0]           pos_y,
  input  logic [3:0]           n_rows,
  output logic                 busy,
  output logic                 done,
  output logic                 collision,
  output logic                 spr_req,
  output logic [3:0]           spr_idx,
  input  logic                 spr_valid,
  input  logic [7:0]           spr_data,
  output logic                 fbuf_en,
  output logic                 fbuf_write,
  output logic [8:0]           fbuf_addr,
  output logic [15:0]          fbuf_in,
  input  logic [15:0]          fbuf_out
);

  blit_state_e             state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    collision_q, collision_d;
  logic                    spr_req_q, spr_req_d;
  logic [N_W-1:0]          spr_idx_q, spr_idx_d;
  logic                    fbuf_en_q, fbuf_en_d;
  logic                    fbuf_write_q, fbuf_write_d;
  logic [ADDR_W-1:0]       fbuf_addr_q, fbuf_addr_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [ROW_IDX_W-1:0]    y_q, y_d;
  logic [N_W-1:0]          n_q, n_d;
  logic [N_W-1:0]          row_q, row_d;
  logic [WORD_BITS-1:0]    mask0_q, mask0_d;
  logic [WORD_BITS-1:0]    mask1_q, mask1_d;
  logic                    straddle_q, straddle_d;

  logic [WORD_BITS-1:0]    shf_mask0;
  logic [WORD_BITS-1:0]    shf_mask1;
  logic                    shf_straddle;
  logic [ROW_IDX_W-1:0]    wy;
  logic [WORD_IDX_W-1:0]   w0;
  logic [WORD_IDX_W-1:0]   w1;
  logic                    advance;
  logic                    last_row;

  sprite_shifter u_shifter (
    .spr_byte (spr_data),
    .x_lo     (x_q[3:0]),
    .mask0    (shf_mask0),
    .mask1    (shf_mask1),
    .straddle (shf_straddle)
  );

  // Both axes wrap: row index mod ROWS, right-hand word mod ROW_WORDS
  always_comb begin
    wy       = y_q + ROW_IDX_W'(row_q);
    w0       = x_q[X_W-1:4];
    w1       = w0 + WORD_IDX_W'(1);
    last_row = (row_q == (n_q - 4'd1));
  end

  // Next-state and next-output logic for the blit sequencer
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    collision_d  = collision_q;
    spr_req_d    = spr_req_q;
    spr_idx_d    = spr_idx_q;
    fbuf_en_d    = fbuf_en_q;
    fbuf_write_d = fbuf_write_q;
    fbuf_addr_d  = fbuf_addr_q;
    x_d          = x_q;
    y_d          = y_q;
    n_d          = n_q;
    row_d        = row_q;
    mask0_d      = mask0_q;
    mask1_d      = mask1_q;
    straddle_d   = straddle_q;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_cls) begin
          state_d      = ST_CLR;
          busy_d       = 1'b1;
          collision_d  = 1'b0;
          fbuf_en_d    = 1'b1;
          fbuf_write_d = 1'b1;
          fbuf_addr_d  = '0;
        end else if (cmd_draw) begin
          x_d         = pos_x;
          y_d         = pos_y;
          n_d         = n_rows;
          row_d       = 4'd0;
          collision_d = 1'b0;
          if (n_rows != 4'd0) begin
            state_d   = ST_FETCH;
            busy_d    = 1'b1;
            spr_req_d = 1'b1;
            spr_idx_d = 4'd0;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (fbuf_addr_q == {ADDR_W{1'b1}}) begin
          state_d      = ST_DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          fbuf_en_d    = 1'b0;
          fbuf_write_d = 1'b0;
        end else begin
          fbuf_addr_d = fbuf_addr_q + ADDR_W'(1);
        end
      end
      ST_FETCH: begin
        if (spr_valid) begin
          mask0_d      = shf_mask0;
          mask1_d      = shf_mask1;
          straddle_d   = shf_straddle;
          spr_req_d    = 1'b0;
          state_d      = ST_RD0;
          fbuf_en_d    = 1'b1;
          fbuf_write_d = 1'b0;
          fbuf_addr_d  = fb_addr(wy, w0);
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_RD0: begin
        state_d      = ST_WR0;
        fbuf_write_d = 1'b1;
      end
      ST_WR0: begin
        collision_d = collision_q | (|(fbuf_out & mask0_q));
        if (straddle_q) begin
          state_d      = ST_RD1;
          fbuf_write_d = 1'b0;
          fbuf_addr_d  = fb_addr(wy, w1);
        end else begin
          advance = 1'b1;
        end
      end
      ST_RD1: begin
        state_d      = ST_WR1;
        fbuf_write_d = 1'b1;
      end
      ST_WR1: begin
        collision_d = collision_q | (|(fbuf_out & mask1_q));
        advance     = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        busy_d       = 1'b0;
        spr_req_d    = 1'b0;
        fbuf_en_d    = 1'b0;
        fbuf_write_d = 1'b0;
      end
    endcase

    // Row finished: either the sprite is complete or fetch the next byte
    if (advance) begin
      fbuf_en_d    = 1'b0;
      fbuf_write_d = 1'b0;
      if (last_row) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d   = ST_FETCH;
        row_d     = row_q + 4'd1;
        spr_idx_d = row_q + 4'd1;
        spr_req_d = 1'b1;
      end
    end else begin
      row_d = row_d;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      collision_q  <= 1'b0;
      spr_req_q    <= 1'b0;
      spr_idx_q    <= 4'd0;
      fbuf_en_q    <= 1'b0;
      fbuf_write_q <= 1'b0;
      fbuf_addr_q  <= '0;
      x_q          <= '0;
      y_q          <= '0;
      n_q          <= 4'd0;
      row_q        <= 4'd0;
      mask0_q      <= 16'h0000;
      mask1_q      <= 16'h0000;
      straddle_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      collision_q  <= collision_d;
      spr_req_q    <= spr_req_d;
      spr_idx_q    <= spr_idx_d;
      fbuf_en_q    <= fbuf_en_d;
      fbuf_write_q <= fbuf_write_d;
      fbuf_addr_q  <= fbuf_addr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      n_q          <= n_d;
      row_q        <= row_d;
      mask0_q      <= mask0_d;
      mask1_q      <= mask1_d;
      straddle_q   <= straddle_d;
    end
  end

  // Write data depends on the word read one cycle earlier, so it follows fbuf_out directly
  always_comb begin
    case (state_q)
      ST_WR0:  fbuf_in = fbuf_out ^ mask0_q;
      ST_WR1:  fbuf_in = fbuf_out ^ mask1_q;
      default: fbuf_in = 16'h0000;
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign collision  = collision_q;
  assign spr_req    = spr_req_q;
  assign spr_idx    = spr_idx_q;
  assign fbuf_en    = fbuf_en_q;
  assign fbuf_write = fbuf_write_q;
  assign fbuf_addr  = fbuf_addr_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a registered-read framebuffer model
// and a sprite-byte responder with configurable wait cycles.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_draw, cmd_cls;
  logic [6:0]  pos_x;
  logic [5:0]  pos_y;
  logic [3:0]  n_rows;
  logic        busy, done, collision, spr_req;
  logic [3:0]  spr_idx;
  logic        spr_valid;
  logic [7:0]  spr_data;
  logic        fbuf_en, fbuf_write;
  logic [8:0]  fbuf_addr;
  logic [15:0] fbuf_in, fbuf_out;

  logic [15:0] mem [0:511];
  logic [7:0]  rom [0:15];
  logic        fill_req;
  int          wait_cnt;
  int          delay_cfg;
  int          poke_cycle;
  int          errors, checks;
  int          cycles, en_cnt, wr_cnt, hs_cnt, idx_bad, en_req, bad;
  logic        got_done;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_draw   (cmd_draw),
    .cmd_cls    (cmd_cls),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .n_rows     (n_rows),
    .busy       (busy),
    .done       (done),
    .collision  (collision),
    .spr_req    (spr_req),
    .spr_idx    (spr_idx),
    .spr_valid  (spr_valid),
    .spr_data   (spr_data),
    .fbuf_en    (fbuf_en),
    .fbuf_write (fbuf_write),
    .fbuf_addr  (fbuf_addr),
    .fbuf_in    (fbuf_in),
    .fbuf_out   (fbuf_out)
  );

  // Framebuffer: registered read, read-before-write; bench can pre-fill a pattern
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= 16'hA5A5 ^ 16'(i);
    end else if (fbuf_en) begin
      if (fbuf_write) mem[fbuf_addr] <= fbuf_in;
      fbuf_out <= mem[fbuf_addr];
    end
  end

  // Sprite responder: valid after delay_cfg waiting cycles of a request
  always @(posedge clk) begin
    if (spr_req && !spr_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign spr_valid = spr_req && (wait_cnt >= delay_cfg);
  assign spr_data  = rom[spr_idx];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic cls, input logic draw, input logic [6:0] x,
                           input logic [5:0] y, input logic [3:0] n);
    @(negedge clk);
    cmd_cls  = cls;
    cmd_draw = draw;
    pos_x    = x;
    pos_y    = y;
    n_rows   = n;
    @(posedge clk);
    #1;
    cmd_cls  = 1'b0;
    cmd_draw = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    cycles = 0; en_cnt = 0; wr_cnt = 0; hs_cnt = 0; idx_bad = 0; en_req = 0;
    got_done = 1'b0;
    while (!got_done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (poke_cycle != 0 && cycles == poke_cycle) begin
        cmd_draw = 1'b1; pos_x = 7'd0; pos_y = 6'd0; n_rows = 4'd1;
      end else begin
        cmd_draw = 1'b0;
      end
      if (fbuf_en) en_cnt++;
      if (fbuf_en && fbuf_write) wr_cnt++;
      if (spr_req && fbuf_en) en_req++;
      if (spr_req && spr_valid) begin
        if (spr_idx != 4'(hs_cnt)) idx_bad++;
        hs_cnt++;
      end
      if (done) got_done = 1'b1;
    end
    cmd_draw = 1'b0;
    chk("done_seen", {63'd0, got_done}, 64'd1);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b1; cmd_draw = 1'b0; cmd_cls = 1'b0;
    pos_x = 7'd0; pos_y = 6'd0; n_rows = 4'd0;
    fill_req = 1'b0; delay_cfg = 0; poke_cycle = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {60'd0, busy, done, collision, spr_req}, 64'd0);
    chk("reset_fbuf", {34'd0, fbuf_en, fbuf_write, fbuf_addr, fbuf_in, spr_idx}, 64'd0);
    rst_n = 1'b1;

    // Full pattern, then CLS
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    start_cmd(1'b1, 1'b0, 7'd0, 6'd0, 4'd0);
    run_until_done(600);
    chk("cls_cycles", 64'(cycles), 64'd513);
    chk("cls_writes", 64'(wr_cnt), 64'd512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== 16'h0000) bad++;
    chk("cls_nonzero", 64'(bad), 64'd0);
    chk("cls_coll", {63'd0, collision}, 64'd0);

    // Aligned draw
    rom[0] = 8'hF0;
    start_cmd(1'b0, 1'b1, 7'd0, 6'd0, 4'd1);
    run_until_done(50);
    chk("a_latency", 64'(cycles), 64'd4);
    chk("a_mem0", {48'd0, mem[0]}, 64'hF000);
    chk("a_coll", {63'd0, collision}, 64'd0);

    // Straddling draw
    rom[0] = 8'hFF;
    start_cmd(1'b0, 1'b1, 7'd12, 6'd2, 4'd1);
    run_until_done(50);
    chk("s_latency", 64'(cycles), 64'd6);
    chk("s_mem_cycles", 64'(en_cnt), 64'd4);
    chk("s_mem16", {48'd0, mem[16]}, 64'h000F);
    chk("s_mem17", {48'd0, mem[17]}, 64'hF000);
    chk("s_coll", {63'd0, collision}, 64'd0);

    // Identical redraw erases and collides
    start_cmd(1'b0, 1'b1, 7'd12, 6'd2, 4'd1);
    run_until_done(50);
    chk("r_mem16", {48'd0, mem[16]}, 64'h0000);
    chk("r_mem17", {48'd0, mem[17]}, 64'h0000);
    chk("r_coll", {63'd0, collision}, 64'd1);

    // N=0 finishes at once, clears collision, no memory traffic
    start_cmd(1'b0, 1'b1, 7'd40, 6'd5, 4'd0);
    run_until_done(20);
    chk("z_latency", 64'(cycles), 64'd1);
    chk("z_mem_cycles", 64'(en_cnt), 64'd0);
    chk("z_coll", {63'd0, collision}, 64'd0);

    start_cmd(1'b1, 1'b0, 7'd0, 6'd0, 4'd0);
    run_until_done(600);

    // Wrap in both axes
    rom[0] = 8'hFF;
    rom[1] = 8'h81;
    start_cmd(1'b0, 1'b1, 7'd124, 6'd63, 4'd2);
    run_until_done(50);
    chk("w_latency", 64'(cycles), 64'd11);
    chk("w_mem511", {48'd0, mem[511]}, 64'h000F);
    chk("w_mem504", {48'd0, mem[504]}, 64'hF000);
    chk("w_mem7", {48'd0, mem[7]}, 64'h0008);
    chk("w_mem0", {48'd0, mem[0]}, 64'h1000);
    chk("w_coll", {63'd0, collision}, 64'd0);

    // Slow handshake, N=15, with a command poked while busy
    for (int i = 0; i < 16; i++) rom[i] = {4'(i), ~4'(i)};
    delay_cfg  = 3;
    poke_cycle = 5;
    start_cmd(1'b0, 1'b1, 7'd5, 6'd10, 4'd15);
    run_until_done(200);
    poke_cycle = 0;
    delay_cfg  = 0;
    chk("h_latency", 64'(cycles), 64'd91);
    chk("h_handshakes", 64'(hs_cnt), 64'd15);
    chk("h_idx_order", 64'(idx_bad), 64'd0);
    chk("h_en_while_req", 64'(en_req), 64'd0);
    chk("h_row0", {48'd0, mem[80]}, 64'h0078);
    chk("h_row14", {48'd0, mem[192]}, 64'h0708);
    bad = 0;
    for (int i = 0; i < 15; i++) if (mem[(10 + i) * 8] !== {5'b0, rom[i], 3'b0}) bad++;
    chk("h_rows", 64'(bad), 64'd0);
    chk("h_word1", {48'd0, mem[81]}, 64'h0000);
    chk("h_mem0_kept", {48'd0, mem[0]}, 64'h1000);
    chk("h_coll", {63'd0, collision}, 64'd0);

    // Reset in the middle of a draw
    for (int i = 0; i < 4; i++) rom[i] = 8'hFF;
    start_cmd(1'b0, 1'b1, 7'd0, 6'd30, 4'd4);
    repeat (3) @(negedge clk);
    chk("m_busy_before", {62'd0, busy, fbuf_en}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("m_reset_ctrl", {60'd0, busy, done, collision, spr_req}, 64'd0);
    chk("m_reset_fbuf", {34'd0, fbuf_en, fbuf_write, fbuf_addr, fbuf_in, spr_idx}, 64'd0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done) bad++;
    end
    chk("m_no_done", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
